axis_weight_sequencer: RTL and testbench
========================================

AXIS_WEIGHT_SEQUENCER -- requirements
Module: axis_weight_sequencer

Interface
REQ-001 SHALL have parameter NUM_W, default 4: number of weight table entries (2..16).
REQ-002 SHALL have parameter WEIGHT_W, default 8: width of each weight (bWeight width).
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESETN  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port cfg_we  input  1  weight table write strobe.
REQ-006 SHALL have port cfg_addr  input  clog2(NUM_W)  weight table write index.
REQ-007 SHALL have port cfg_wdata  input  WEIGHT_W  weight to write.
REQ-008 SHALL have port cfg_count  input  clog2(NUM_W)+1  number of active weights per frame, sampled on IDLE->RUN.
REQ-009 SHALL have port enable  input  1  run request (level).
REQ-010 SHALL have ports s_axis_tvalid / s_axis_tlast  input  1 / 1  upstream stream control.
REQ-011 SHALL have port s_axis_tready  output  1  upstream ready.
REQ-012 SHALL have ports m_axis_tvalid / m_axis_tlast  output  1 / 1  control to multiplier.
REQ-013 SHALL have port m_axis_tready  input  1  multiplier ready.
REQ-014 SHALL have port bWeight  output  WEIGHT_W  weight for current packet.
REQ-015 SHALL have port weight_idx  output  clog2(NUM_W)  active table index.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse on frame wrap.
REQ-017 SHALL have port frame_cnt  output  16  completed-frame count.
REQ-018 SHALL have port busy  output  1  high in RUN or DRAIN.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-020 IDLE: s_axis_tready=0, m_axis_tvalid=0; go RUN when enable=1 and cfg_count in 1..NUM_W, latching cfg_count; else stay IDLE.
REQ-021 RUN/DRAIN: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tlast=s_axis_tlast, all combinational, zero latency.
REQ-022 Beat accepted when s_axis_tvalid and m_axis_tready both high in RUN/DRAIN.
REQ-023 bWeight SHALL equal table[weight_idx] from registered index; constant within a packet.
REQ-024 On accepted beat with tlast: weight_idx increments; if weight_idx = latched count-1, weight_idx wraps to 0, frame_done pulses next cycle, frame_cnt increments (wraps 0xFFFF->0).
REQ-025 New weight SHALL be presented on the cycle following the tlast beat, ready for the next packet's first beat.
REQ-026 RUN with enable=0: go DRAIN if a packet is in progress (any beat accepted since last tlast), else IDLE.
REQ-027 DRAIN: on accepted tlast beat, apply REQ-024 then go IDLE; enable reasserted in DRAIN SHALL be ignored until IDLE.
REQ-028 Entering RUN from IDLE SHALL NOT reset weight_idx; it resumes at the stored index, clamped to 0 if >= new latched count.
REQ-029 cfg_we with cfg_addr >= NUM_W SHALL be ignored.
REQ-030 busy SHALL be 1 exactly in RUN and DRAIN.

Reset
REQ-031 RESETN low SHALL force IDLE, weight_idx=0, frame_cnt=0, frame_done=0, latched count=1, all table entries 0, bWeight=0, s_axis_tready=0, m_axis_tvalid=0; mid-packet reset discards the packet.

Configuration
REQ-032 Macro WEIGHT_SHADOW_EN defined: cfg writes go to a shadow table; shadow copies to active table in IDLE every cycle and in RUN/DRAIN only on the frame-wrap tlast beat; a same-cycle write is included in the copy.
REQ-033 WEIGHT_SHADOW_EN undefined: cfg writes go directly to the active table next cycle, including mid-packet (bWeight changes mid-packet when the active index is written).

Verification
REQ-034 Reset, table={10,20,30,40}, cfg_count=4, enable=1, four 3-beat packets, m_axis_tready=1 -> bWeight 10,20,30,40 per packet; frame_done one pulse; frame_cnt=1.
REQ-035 m_axis_tready toggling 1-0-1 during a packet -> s_axis_tready mirrors it; weight_idx changes only after tlast beat.
REQ-036 enable dropped after beat 2 of 4-beat packet -> DRAIN, busy=1 until tlast accepted, then IDLE; weight_idx advanced by 1.
REQ-037 With WEIGHT_SHADOW_EN: write addr 0=99 mid-frame -> bWeight stays 10 until frame wrap, then 99; without the macro, 99 appears next cycle.
REQ-038 cfg_count=0 with enable=1 -> remains IDLE, s_axis_tready=0; RESETN low mid-packet -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/axis_weight_sequencer.sv
// Per-packet weight sequencer: walks a small weight table once per AXI-Stream packet and wraps per frame.
// Optional macro WEIGHT_SHADOW_EN: config writes land in a shadow table that is copied in at frame boundaries.
module axis_weight_sequencer #(
    parameter int NUM_W    = 4,
    parameter int WEIGHT_W = 8
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_W)-1:0]   cfg_addr,
    input  logic [WEIGHT_W-1:0]        cfg_wdata,
    input  logic [$clog2(NUM_W):0]     cfg_count,
    input  logic                       enable,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [WEIGHT_W-1:0]        bWeight,
    output logic [$clog2(NUM_W)-1:0]   weight_idx,
    output logic                       frame_done,
    output logic [15:0]                frame_cnt,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_W);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 in_pkt_q, in_pkt_d;
    logic                 frame_done_q, frame_done_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [WEIGHT_W-1:0]  tbl_q [NUM_W];
    logic [WEIGHT_W-1:0]  tbl_d [NUM_W];
`ifdef WEIGHT_SHADOW_EN
    logic [WEIGHT_W-1:0]  shd_q [NUM_W];
    logic [WEIGHT_W-1:0]  shd_d [NUM_W];
`endif

    logic                 active_s;
    logic                 accept_s;
    logic                 last_acc_s;
    logic                 wrap_s;
    logic                 cfg_ok_s;
    logic                 write_ok_s;

    // Handshake qualifiers shared by the FSM and table logic
    always_comb begin
        active_s   = (state_q != ST_IDLE);
        accept_s   = active_s && s_axis_tvalid && m_axis_tready;
        last_acc_s = accept_s && s_axis_tlast;
        wrap_s     = last_acc_s && ({1'b0, idx_q} == (count_q - CNT_W'(1)));
        cfg_ok_s   = (cfg_count != CNT_W'(0)) && (32'(cfg_count) <= NUM_W);
        write_ok_s = cfg_we && (32'(cfg_addr) < NUM_W);
    end

    // Next-state, index advance and frame accounting
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        in_pkt_d     = in_pkt_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (accept_s) begin
            in_pkt_d = !s_axis_tlast;
        end else begin
            in_pkt_d = in_pkt_q;
        end

        if (last_acc_s) begin
            if (wrap_s) begin
                idx_d        = IDX_W'(0);
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && cfg_ok_s) begin
                    state_d = ST_RUN;
                    count_d = cfg_count;
                    // Resume at the stored index unless it falls outside the new frame length
                    if ({1'b0, idx_q} >= cfg_count) begin
                        idx_d = IDX_W'(0);
                    end else begin
                        idx_d = idx_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = in_pkt_d ? ST_DRAIN : ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (last_acc_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Weight table update; the shadow copy includes a write made in the copy cycle
    always_comb begin
        tbl_d = tbl_q;
`ifdef WEIGHT_SHADOW_EN
        shd_d = shd_q;
        if (write_ok_s) begin
            shd_d[cfg_addr] = cfg_wdata;
        end else begin
            shd_d = shd_q;
        end
        if ((state_q == ST_IDLE) || wrap_s) begin
            tbl_d = shd_d;
        end else begin
            tbl_d = tbl_q;
        end
`else
        if (write_ok_s) begin
            tbl_d[cfg_addr] = cfg_wdata;
        end else begin
            tbl_d = tbl_q;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            count_q      <= CNT_W'(1);
            idx_q        <= IDX_W'(0);
            in_pkt_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
            for (int i = 0; i < NUM_W; i++) begin
                tbl_q[i] <= '0;
`ifdef WEIGHT_SHADOW_EN
                shd_q[i] <= '0;
`endif
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            in_pkt_q     <= in_pkt_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            tbl_q        <= tbl_d;
`ifdef WEIGHT_SHADOW_EN
            shd_q        <= shd_d;
`endif
        end
    end

    // Zero-latency stream pass-through, gated off while idle
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (active_s) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
        end else begin
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
        end
    end

    assign bWeight    = tbl_q[idx_q];
    assign weight_idx = idx_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = active_s;

endmodule

// File: tb/tb_axis_weight_sequencer.sv
// Scoreboard bench for axis_weight_sequencer: expected weight/tlast per beat queued by the driver, checked by a monitor.
module tb_axis_weight_sequencer;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [2:0]  cfg_count;
    logic        enable;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [7:0]  bWeight;
    logic [1:0]  weight_idx;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    logic [8:0] exp_q[$];

    axis_weight_sequencer #(.NUM_W(4), .WEIGHT_W(8)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_count(cfg_count),
        .enable(enable),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .bWeight(bWeight), .weight_idx(weight_idx), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every beat handed to the multiplier is compared against the queue head
    always @(negedge CLK) begin
        if (RESETN && m_axis_tvalid && m_axis_tready) begin
            logic [8:0] e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got w=%0d last=%0d expected none", bWeight, m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                if ({m_axis_tlast, bWeight} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got w=%0d last=%0d expected w=%0d last=%0d",
                             bWeight, m_axis_tlast, e[7:0], e[8]);
                end
            end
        end
        if (RESETN && frame_done) n_pulse++;
    end

    // Present one beat and wait (bounded) for its acceptance; returns 1 time unit after the accepting edge
    task automatic beat(input logic last, input logic [7:0] w);
        bit done = 1'b0;
        exp_q.push_back({last, w});
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge CLK);
            done = s_axis_tready && m_axis_tready;
            @(posedge CLK);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: got no accept expected accept within 50 cycles");
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge CLK); #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        logic [7:0] w_mid;
`ifdef WEIGHT_SHADOW_EN
        w_mid = 8'd30;
`else
        w_mid = 8'd66;
`endif
        RESETN = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0; cfg_count = 3'd4;
        enable = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_bweight", bWeight, 0);
        check("rst_idx", weight_idx, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_frame_done", frame_done, 0);

        // Table load while idle; count of zero must not start a run
        enable = 1'b0; s_axis_tvalid = 1'b0; cfg_count = 3'd0;
        @(posedge CLK); #1;
        RESETN = 1'b1;
        @(posedge CLK); #1;
        wr(2'd0, 8'd10); wr(2'd1, 8'd20); wr(2'd2, 8'd30); wr(2'd3, 8'd40);
        enable = 1'b1; s_axis_tvalid = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("cnt0_busy", busy, 0);
        check("cnt0_s_tready", s_axis_tready, 0);
        check("idle_bweight", bWeight, 10);
        @(posedge CLK); #1;
        s_axis_tvalid = 1'b0;
        cfg_count = 3'd4;
        @(posedge CLK); #1;

        // Four 3-beat packets make one frame
        for (int p = 0; p < 4; p++) begin
            beat(1'b0, 8'(10 * (p + 1)));
            beat(1'b0, 8'(10 * (p + 1)));
            beat(1'b1, 8'(10 * (p + 1)));
        end
        @(negedge CLK);
        check("frame1_done", frame_done, 1);
        check("frame1_cnt", frame_cnt, 1);
        check("frame1_idx", weight_idx, 0);

        // Backpressure mid-packet: ready mirrors, index holds
        @(posedge CLK); #1;
        beat(1'b0, 8'd10);
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
        @(negedge CLK);
        check("bp_s_tready", s_axis_tready, 0);
        check("bp_m_tvalid", m_axis_tvalid, 1);
        check("bp_idx", weight_idx, 0);
        @(posedge CLK); #1;
        m_axis_tready = 1'b1;
        beat(1'b0, 8'd10);
        beat(1'b1, 8'd10);
        @(negedge CLK);
        check("bp_idx_after", weight_idx, 1);
        check("bp_bweight_after", bWeight, 20);
        check("frame_done_single", frame_done, 0);

        // Enable dropped mid-packet: drain, then idle despite enable coming back
        @(posedge CLK); #1;
        beat(1'b0, 8'd20);
        beat(1'b0, 8'd20);
        enable = 1'b0;
        @(posedge CLK); #1;
        enable = 1'b1;
        @(negedge CLK);
        check("drain_busy", busy, 1);
        check("drain_idx", weight_idx, 1);
        @(posedge CLK); #1;
        beat(1'b0, 8'd20);
        beat(1'b1, 8'd20);
        s_axis_tvalid = 1'b1;
        @(negedge CLK);
        check("drain_to_idle_busy", busy, 0);
        check("drain_to_idle_s_tready", s_axis_tready, 0);
        check("drain_idx_adv", weight_idx, 2);
        @(posedge CLK); #1;
        s_axis_tvalid = 1'b0;
        @(negedge CLK);
        check("rerun_busy", busy, 1);
        @(posedge CLK); #1;

        // Config writes while running
        beat(1'b0, 8'd30);
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'd66;
        @(posedge CLK); #1;
        cfg_addr = 2'd0; cfg_wdata = 8'd99;
        @(negedge CLK);
        check("mid_write_bweight", bWeight, w_mid);
        @(posedge CLK); #1;
        cfg_we = 1'b0;
        beat(1'b0, w_mid);
        beat(1'b1, w_mid);
        beat(1'b1, 8'd40);
        @(negedge CLK);
        check("frame2_cnt", frame_cnt, 2);
        check("wrap_bweight", bWeight, 99);
        @(posedge CLK); #1;
        beat(1'b1, 8'd99);

        // Re-enter with a shorter frame: stored index 1 clamps to 0
        enable = 1'b0; cfg_count = 3'd1;
        @(posedge CLK); #1;
        enable = 1'b1;
        @(negedge CLK);
        check("clamp_idle_busy", busy, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("clamp_idx", weight_idx, 0);
        check("clamp_busy", busy, 1);
        @(posedge CLK); #1;
        beat(1'b1, 8'd99);
        @(negedge CLK);
        check("frame3_cnt", frame_cnt, 3);
        check("frame3_idx", weight_idx, 0);
        @(posedge CLK); #1;
        check("pulse_count", n_pulse, 3);

        // Reset in the middle of a packet
        beat(1'b0, 8'd99);
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        RESETN = 1'b0;
        #1;
        check("mid_rst_s_tready", s_axis_tready, 0);
        check("mid_rst_m_tvalid", m_axis_tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bweight", bWeight, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        repeat (2) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
